// File: rtl/pq_cmd_arbiter.sv
// rtl/pq_cmd_arbiter.sv - round-robin command arbiter/sequencer for the array priority queue
module pq_cmd_arbiter #(
   parameter int NR     = 4,
   parameter int TW     = 4,
   parameter int PW     = 8,
   parameter int DEPTH  = 8,
   parameter int TO_CYC = 15
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [NR-1:0]              req_i,
   input  logic [2*NR-1:0]            op_i,
   input  logic [TW*NR-1:0]           id_i,
   input  logic [PW*NR-1:0]           prio_i,
   output logic [NR-1:0]              gnt_o,
   output logic                       rsp_vld_o,
   output logic [$clog2(NR)-1:0]      rsp_idx_o,
   output logic [1:0]                 rsp_err_o,
   output logic [TW-1:0]              rsp_id_o,
   output logic [PW-1:0]              rsp_prio_o,
   output logic                       pq_push_o,
   output logic                       pq_pop_o,
   output logic                       pq_drop_o,
   output logic [TW-1:0]              pq_id_o,
   output logic [PW-1:0]              pq_prio_o,
   output logic [TW-1:0]              pq_drop_id_o,
   input  logic                       pq_push_vld_i,
   input  logic                       pq_pop_vld_i,
   input  logic                       pq_drop_vld_i,
   input  logic                       pq_drop_hit_i,
   input  logic [TW-1:0]              pq_id_i,
   input  logic [PW-1:0]              pq_prio_i,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic                       busy_o
);
   localparam int IW = $clog2(NR);
   localparam int CW = $clog2(DEPTH+1);

   localparam logic [1:0] OP_PUSH = 2'b00;
   localparam logic [1:0] OP_POP  = 2'b01;
   localparam logic [1:0] OP_DROP = 2'b10;
   localparam logic [1:0] OP_RSVD = 2'b11;

   localparam logic [1:0] ERR_OK    = 2'b00;
   localparam logic [1:0] ERR_FULL  = 2'b01;
   localparam logic [1:0] ERR_EMPTY = 2'b10;
   localparam logic [1:0] ERR_TO    = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d, idx_q, idx_d;
   logic [1:0]      op_q, op_d, err_q, err_d;
   logic [TW-1:0]   id_q, id_d, rid_q, rid_d;
   logic [PW-1:0]   prio_q, prio_d, rprio_q, rprio_d;
   logic [7:0]      to_q, to_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            iss_q, iss_d;

   logic            win_found;
   logic [IW-1:0]   win_idx;
   logic [1:0]      win_op;
   logic [TW-1:0]   win_id;
   logic [PW-1:0]   win_prio;
   logic            full, empty, vld_match, oper_vld;

   assign full  = (cnt_q == CW'(DEPTH));
   assign empty = (cnt_q == '0);

   // Rotating priority: search starts one past the last winner.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 1; k <= NR; k++) begin
         if (!win_found && req_i[(int'(ptr_q) + k) % NR]) begin
            win_found = 1'b1;
            win_idx   = IW'((int'(ptr_q) + k) % NR);
         end
      end
   end

   assign win_op   = op_i[int'(win_idx)*2 +: 2];
   assign win_id   = id_i[int'(win_idx)*TW +: TW];
   assign win_prio = prio_i[int'(win_idx)*PW +: PW];

   assign vld_match = (op_q == OP_PUSH && pq_push_vld_i) ||
                      (op_q == OP_POP  && pq_pop_vld_i)  ||
                      (op_q == OP_DROP && pq_drop_vld_i);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         ptr_q   <= IW'(NR-1);
         idx_q   <= '0;
         op_q    <= '0;
         err_q   <= '0;
         id_q    <= '0;
         prio_q  <= '0;
         rid_q   <= '0;
         rprio_q <= '0;
         to_q    <= '0;
         cnt_q   <= '0;
         iss_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         op_q    <= op_d;
         err_q   <= err_d;
         id_q    <= id_d;
         prio_q  <= prio_d;
         rid_q   <= rid_d;
         rprio_q <= rprio_d;
         to_q    <= to_d;
         cnt_q   <= cnt_d;
         iss_q   <= iss_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      op_d    = op_q;
      err_d   = err_q;
      id_d    = id_q;
      prio_d  = prio_q;
      rid_d   = rid_q;
      rprio_d = rprio_q;
      to_d    = to_q;
      cnt_d   = cnt_q;
      iss_d   = iss_q;
      case (state_q)
         S_IDLE: begin
            iss_d = 1'b0;
            if (win_found) begin
               ptr_d   = win_idx;
               idx_d   = win_idx;
               op_d    = win_op;
               id_d    = win_id;
               prio_d  = win_prio;
               rid_d   = (win_op == OP_POP) ? '0 : win_id;
               rprio_d = (win_op == OP_PUSH) ? win_prio : '0;
               err_d   = ERR_OK;
               // Illegal requests are answered without ever touching the queue.
               if (win_op == OP_RSVD) begin
                  err_d   = ERR_EMPTY;
                  state_d = S_RESP;
               end else if (win_op == OP_PUSH && full) begin
                  err_d   = ERR_FULL;
                  state_d = S_RESP;
               end else if (win_op != OP_PUSH && empty) begin
                  err_d   = ERR_EMPTY;
                  state_d = S_RESP;
               end else begin
                  iss_d   = 1'b1;
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            to_d    = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (vld_match) begin
               state_d = S_RESP;
               if (op_q == OP_POP) begin
                  rid_d   = pq_id_i;
                  rprio_d = pq_prio_i;
               end
               if (op_q == OP_DROP && !pq_drop_hit_i) err_d = ERR_EMPTY;
            end else if (to_q == 8'(TO_CYC - 1)) begin
               err_d   = ERR_TO;
               state_d = S_RESP;
            end else begin
               to_d = to_q + 8'd1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
            if (err_q == ERR_OK) begin
               if (op_q == OP_PUSH) cnt_d = cnt_q + CW'(1);
               else                 cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign oper_vld = (state_q != S_IDLE) && iss_q;

   always_comb begin
      gnt_o = '0;
      if (state_q == S_IDLE && win_found) gnt_o[win_idx] = 1'b1;
      rsp_vld_o    = (state_q == S_RESP);
      rsp_idx_o    = rsp_vld_o ? idx_q : '0;
      rsp_err_o    = rsp_vld_o ? err_q : '0;
      rsp_id_o     = rsp_vld_o ? rid_q : '0;
      rsp_prio_o   = rsp_vld_o ? rprio_q : '0;
      pq_push_o    = (state_q == S_ISSUE) && (op_q == OP_PUSH);
      pq_pop_o     = (state_q == S_ISSUE) && (op_q == OP_POP);
      pq_drop_o    = (state_q == S_ISSUE) && (op_q == OP_DROP);
      pq_id_o      = (oper_vld && op_q == OP_PUSH) ? id_q : '0;
      pq_prio_o    = (oper_vld && op_q == OP_PUSH) ? prio_q : '0;
      pq_drop_id_o = (oper_vld && op_q == OP_DROP) ? id_q : '0;
      count_o      = cnt_q;
      full_o       = full;
      empty_o      = empty;
      busy_o       = (state_q != S_IDLE);
   end
endmodule

// File: tb/tb_pq_cmd_arbiter.sv
// tb/tb_pq_cmd_arbiter.sv - directed self-checking bench for pq_cmd_arbiter
module tb_pq_cmd_arbiter;
   localparam int NR = 4, TW = 4, PW = 8, DEPTH = 8, TO_CYC = 15;
   localparam logic [1:0] PUSH = 2'b00, POP = 2'b01, DROP = 2'b10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_ni;
   logic [3:0]    req_i;
   logic [7:0]    op_i;
   logic [15:0]   id_i;
   logic [31:0]   prio_i;
   logic [3:0]    gnt_o;
   logic          rsp_vld_o;
   logic [1:0]    rsp_idx_o;
   logic [1:0]    rsp_err_o;
   logic [3:0]    rsp_id_o;
   logic [7:0]    rsp_prio_o;
   logic          pq_push_o, pq_pop_o, pq_drop_o;
   logic [3:0]    pq_id_o, pq_drop_id_o;
   logic [7:0]    pq_prio_o;
   logic          pq_push_vld_i, pq_pop_vld_i, pq_drop_vld_i, pq_drop_hit_i;
   logic [3:0]    pq_id_i;
   logic [7:0]    pq_prio_i;
   logic [3:0]    count_o;
   logic          full_o, empty_o, busy_o;

   int checks = 0;
   int failures = 0;

   pq_cmd_arbiter #(.NR(NR), .TW(TW), .PW(PW), .DEPTH(DEPTH), .TO_CYC(TO_CYC)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .op_i(op_i), .id_i(id_i), .prio_i(prio_i),
      .gnt_o(gnt_o), .rsp_vld_o(rsp_vld_o), .rsp_idx_o(rsp_idx_o), .rsp_err_o(rsp_err_o),
      .rsp_id_o(rsp_id_o), .rsp_prio_o(rsp_prio_o), .pq_push_o(pq_push_o), .pq_pop_o(pq_pop_o),
      .pq_drop_o(pq_drop_o), .pq_id_o(pq_id_o), .pq_prio_o(pq_prio_o), .pq_drop_id_o(pq_drop_id_o),
      .pq_push_vld_i(pq_push_vld_i), .pq_pop_vld_i(pq_pop_vld_i), .pq_drop_vld_i(pq_drop_vld_i),
      .pq_drop_hit_i(pq_drop_hit_i), .pq_id_i(pq_id_i), .pq_prio_i(pq_prio_i),
      .count_o(count_o), .full_o(full_o), .empty_o(empty_o), .busy_o(busy_o)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_vld;
      pq_push_vld_i = 1'b0;
      pq_pop_vld_i  = 1'b0;
      pq_drop_vld_i = 1'b0;
      pq_drop_hit_i = 1'b0;
      pq_id_i       = '0;
      pq_prio_i     = '0;
   endtask

   task automatic do_reset;
      req_i = '0; op_i = '0; id_i = '0; prio_i = '0;
      clear_vld();
      rst_ni = 1'b0;
      tick();
      tick();
      rst_ni = 1'b1;
      #1;
   endtask

   task automatic set_req(input int r, input logic [1:0] op, input logic [3:0] id, input logic [7:0] prio);
      req_i[r]        = 1'b1;
      op_i[r*2 +: 2]  = op;
      id_i[r*4 +: 4]  = id;
      prio_i[r*8 +: 8] = prio;
   endtask

   // resp: 0 = no completion, 1 = matching completion, 2 = wrong completion strobe
   task automatic run_op(input int r, input logic [1:0] op, input logic [3:0] id, input logic [7:0] prio,
                         input int resp, input logic [3:0] ret_id, input logic [7:0] ret_prio, input logic hit,
                         output int lat, output logic [1:0] err, output logic [3:0] rid,
                         output logic [7:0] rprio, output int ridx);
      lat = -1; err = '0; rid = '0; rprio = '0; ridx = -1;
      set_req(r, op, id, prio);
      #1;
      if (gnt_o == '0) begin
         req_i = '0;
         return;
      end
      tick();
      req_i = '0;
      if (rsp_vld_o) begin
         lat = 1; err = rsp_err_o; rid = rsp_id_o; rprio = rsp_prio_o; ridx = int'(rsp_idx_o);
         return;
      end
      tick();
      if (resp == 1) begin
         case (op)
            PUSH: pq_push_vld_i = 1'b1;
            POP: begin pq_pop_vld_i = 1'b1; pq_id_i = ret_id; pq_prio_i = ret_prio; end
            default: begin pq_drop_vld_i = 1'b1; pq_drop_hit_i = hit; end
         endcase
      end else if (resp == 2) begin
         if (op == PUSH) begin pq_pop_vld_i = 1'b1; pq_id_i = 4'hA; end
         else pq_push_vld_i = 1'b1;
      end
      for (int c = 3; c < 40; c++) begin
         tick();
         clear_vld();
         if (rsp_vld_o) begin
            lat = c; err = rsp_err_o; rid = rsp_id_o; rprio = rsp_prio_o; ridx = int'(rsp_idx_o);
            return;
         end
      end
   endtask

   task automatic test_reset;
      do_reset();
      checks++;
      if ({gnt_o, rsp_vld_o, pq_push_o, pq_pop_o, pq_drop_o, busy_o, full_o} !== '0) begin
         failures++;
         $display("FAIL reset_ctrl: got %b expected 0", {gnt_o, rsp_vld_o, pq_push_o, pq_pop_o, pq_drop_o, busy_o, full_o});
      end
      checks++;
      if ({rsp_idx_o, rsp_err_o, rsp_id_o, rsp_prio_o, pq_id_o, pq_prio_o, pq_drop_id_o} !== '0) begin
         failures++;
         $display("FAIL reset_data: got %h expected 0", {rsp_idx_o, rsp_err_o, rsp_id_o, rsp_prio_o, pq_id_o, pq_prio_o, pq_drop_id_o});
      end
      checks++;
      if (count_o !== 4'd0 || empty_o !== 1'b1) begin
         failures++;
         $display("FAIL reset_count: got count=%0d empty=%b expected 0/1", count_o, empty_o);
      end
   endtask

   task automatic test_push_basic;
      set_req(0, PUSH, 4'd3, 8'd5);
      #1;
      checks++;
      if (gnt_o !== 4'b0001) begin failures++; $display("FAIL push_gnt: got %b expected 0001", gnt_o); end
      tick();
      req_i = '0;
      checks++;
      if ({pq_push_o, pq_pop_o, pq_drop_o} !== 3'b100 || pq_id_o !== 4'd3 || pq_prio_o !== 8'd5) begin
         failures++;
         $display("FAIL push_issue: got cmd=%b id=%0d prio=%0d expected 100/3/5", {pq_push_o, pq_pop_o, pq_drop_o}, pq_id_o, pq_prio_o);
      end
      tick();
      pq_push_vld_i = 1'b1;
      #1;
      checks++;
      if (pq_push_o !== 1'b0 || rsp_vld_o !== 1'b0 || busy_o !== 1'b1 || pq_id_o !== 4'd3 || gnt_o !== 4'b0000) begin
         failures++;
         $display("FAIL push_wait: got push=%b rsp=%b busy=%b id=%0d gnt=%b expected 0/0/1/3/0000", pq_push_o, rsp_vld_o, busy_o, pq_id_o, gnt_o);
      end
      tick();
      pq_push_vld_i = 1'b0;
      checks++;
      if (rsp_vld_o !== 1'b1 || rsp_err_o !== 2'b00 || rsp_idx_o !== 2'd0 || rsp_id_o !== 4'd3 || rsp_prio_o !== 8'd5) begin
         failures++;
         $display("FAIL push_rsp: got vld=%b err=%b idx=%0d id=%0d prio=%0d expected 1/00/0/3/5", rsp_vld_o, rsp_err_o, rsp_idx_o, rsp_id_o, rsp_prio_o);
      end
      tick();
      checks++;
      if (count_o !== 4'd1 || empty_o !== 1'b0 || busy_o !== 1'b0 || rsp_vld_o !== 1'b0 || pq_id_o !== 4'd0) begin
         failures++;
         $display("FAIL push_after: got count=%0d empty=%b busy=%b rsp=%b id=%0d expected 1/0/0/0/0", count_o, empty_o, busy_o, rsp_vld_o, pq_id_o);
      end
   endtask

   task automatic test_round_robin;
      do_reset();
      for (int r = 0; r < NR; r++) set_req(r, PUSH, 4'(r + 1), 8'(16 + r));
      #1;
      for (int k = 0; k < NR; k++) begin
         checks++;
         if (gnt_o !== 4'(1 << k)) begin failures++; $display("FAIL rr_gnt%0d: got %b expected %b", k, gnt_o, 4'(1 << k)); end
         tick();
         req_i[k] = 1'b0;
         checks++;
         if (gnt_o !== 4'b0000 || pq_id_o !== 4'(k + 1)) begin
            failures++;
            $display("FAIL rr_issue%0d: got gnt=%b id=%0d expected 0000/%0d", k, gnt_o, pq_id_o, k + 1);
         end
         tick();
         pq_push_vld_i = 1'b1;
         tick();
         pq_push_vld_i = 1'b0;
         checks++;
         if (rsp_vld_o !== 1'b1 || rsp_idx_o !== 2'(k) || rsp_err_o !== 2'b00) begin
            failures++;
            $display("FAIL rr_rsp%0d: got vld=%b idx=%0d err=%b expected 1/%0d/00", k, rsp_vld_o, rsp_idx_o, rsp_err_o, k);
         end
         tick();
      end
      checks++;
      if (count_o !== 4'd4) begin failures++; $display("FAIL rr_count: got %0d expected 4", count_o); end
   endtask

   task automatic test_full;
      int lat, ridx, bad;
      logic [1:0] err;
      logic [3:0] rid;
      logic [7:0] rprio;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         run_op(0, PUSH, 4'(5 + i), 8'(i), 1, '0, '0, 1'b0, lat, err, rid, rprio, ridx);
         if (lat != 3 || err != 2'b00) bad++;
         tick();
      end
      checks++;
      if (bad != 0 || count_o !== 4'd8 || full_o !== 1'b1) begin
         failures++;
         $display("FAIL fill: got bad=%0d count=%0d full=%b expected 0/8/1", bad, count_o, full_o);
      end
      set_req(2, PUSH, 4'd9, 8'd1);
      #1;
      checks++;
      if (gnt_o !== 4'b0100) begin failures++; $display("FAIL full_gnt: got %b expected 0100", gnt_o); end
      tick();
      req_i = '0;
      checks++;
      if (pq_push_o !== 1'b0 || rsp_vld_o !== 1'b1 || rsp_err_o !== 2'b01 || rsp_idx_o !== 2'd2) begin
         failures++;
         $display("FAIL full_rsp: got push=%b vld=%b err=%b idx=%0d expected 0/1/01/2", pq_push_o, rsp_vld_o, rsp_err_o, rsp_idx_o);
      end
      tick();
      checks++;
      if (count_o !== 4'd8 || full_o !== 1'b1) begin failures++; $display("FAIL full_hold: got count=%0d full=%b expected 8/1", count_o, full_o); end
   endtask

   task automatic test_pop;
      int lat, ridx;
      logic [1:0] err;
      logic [3:0] rid;
      logic [7:0] rprio;
      do_reset();
      run_op(1, POP, '0, '0, 1, '0, '0, 1'b0, lat, err, rid, rprio, ridx);
      checks++;
      if (lat != 1 || err !== 2'b10 || ridx != 1) begin
         failures++;
         $display("FAIL pop_empty: got lat=%0d err=%b idx=%0d expected 1/10/1", lat, err, ridx);
      end
      tick();
      run_op(1, PUSH, 4'd7, 8'd9, 1, '0, '0, 1'b0, lat, err, rid, rprio, ridx);
      tick();
      run_op(3, POP, '0, '0, 1, 4'd7, 8'd9, 1'b0, lat, err, rid, rprio, ridx);
      checks++;
      if (lat != 3 || err !== 2'b00 || rid !== 4'd7 || rprio !== 8'd9 || ridx != 3) begin
         failures++;
         $display("FAIL pop_data: got lat=%0d err=%b id=%0d prio=%0d idx=%0d expected 3/00/7/9/3", lat, err, rid, rprio, ridx);
      end
      tick();
      checks++;
      if (count_o !== 4'd0 || empty_o !== 1'b1) begin failures++; $display("FAIL pop_count: got %0d/%b expected 0/1", count_o, empty_o); end
   endtask

   task automatic test_drop;
      int lat, ridx;
      logic [1:0] err;
      logic [3:0] rid;
      logic [7:0] rprio;
      run_op(2, PUSH, 4'd4, 8'd3, 1, '0, '0, 1'b0, lat, err, rid, rprio, ridx);
      tick();
      set_req(2, DROP, 4'd4, '0);
      #1;
      tick();
      req_i = '0;
      checks++;
      if (pq_drop_o !== 1'b1 || pq_drop_id_o !== 4'd4 || pq_push_o !== 1'b0) begin
         failures++;
         $display("FAIL drop_issue: got drop=%b id=%0d push=%b expected 1/4/0", pq_drop_o, pq_drop_id_o, pq_push_o);
      end
      tick();
      pq_drop_vld_i = 1'b1;
      pq_drop_hit_i = 1'b0;
      tick();
      clear_vld();
      checks++;
      if (rsp_vld_o !== 1'b1 || rsp_err_o !== 2'b10 || rsp_id_o !== 4'd4) begin
         failures++;
         $display("FAIL drop_miss: got vld=%b err=%b id=%0d expected 1/10/4", rsp_vld_o, rsp_err_o, rsp_id_o);
      end
      tick();
      checks++;
      if (count_o !== 4'd1) begin failures++; $display("FAIL drop_miss_count: got %0d expected 1", count_o); end
      run_op(0, DROP, 4'd4, '0, 1, '0, '0, 1'b1, lat, err, rid, rprio, ridx);
      checks++;
      if (lat != 3 || err !== 2'b00 || rid !== 4'd4) begin
         failures++;
         $display("FAIL drop_hit: got lat=%0d err=%b id=%0d expected 3/00/4", lat, err, rid);
      end
      tick();
      checks++;
      if (count_o !== 4'd0) begin failures++; $display("FAIL drop_hit_count: got %0d expected 0", count_o); end
   endtask

   task automatic test_timeout;
      int lat, ridx;
      logic [1:0] err;
      logic [3:0] rid;
      logic [7:0] rprio;
      run_op(0, PUSH, 4'd2, 8'd2, 1, '0, '0, 1'b0, lat, err, rid, rprio, ridx);
      tick();
      run_op(1, PUSH, 4'd5, 8'd6, 0, '0, '0, 1'b0, lat, err, rid, rprio, ridx);
      checks++;
      if (lat != TO_CYC + 2 || err !== 2'b11) begin
         failures++;
         $display("FAIL timeout_none: got lat=%0d err=%b expected %0d/11", lat, err, TO_CYC + 2);
      end
      tick();
      run_op(2, PUSH, 4'd6, 8'd6, 2, '0, '0, 1'b0, lat, err, rid, rprio, ridx);
      checks++;
      if (lat != TO_CYC + 2 || err !== 2'b11) begin
         failures++;
         $display("FAIL timeout_wrong_vld: got lat=%0d err=%b expected %0d/11", lat, err, TO_CYC + 2);
      end
      tick();
      checks++;
      if (count_o !== 4'd1) begin failures++; $display("FAIL timeout_count: got %0d expected 1", count_o); end
   endtask

   task automatic test_reset_in_wait;
      int lat, ridx;
      logic [1:0] err;
      logic [3:0] rid;
      logic [7:0] rprio;
      set_req(3, PUSH, 4'd6, 8'd6);
      #1;
      tick();
      req_i = '0;
      tick();
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      #1;
      checks++;
      if (busy_o !== 1'b0 || count_o !== 4'd0 || empty_o !== 1'b1 ||
          {rsp_vld_o, pq_push_o, pq_id_o, pq_prio_o, gnt_o} !== '0) begin
         failures++;
         $display("FAIL reset_wait: got busy=%b count=%0d empty=%b rsp=%b id=%0d expected 0/0/1/0/0", busy_o, count_o, empty_o, rsp_vld_o, pq_id_o);
      end
      run_op(0, POP, '0, '0, 1, '0, '0, 1'b0, lat, err, rid, rprio, ridx);
      checks++;
      if (lat != 1 || err !== 2'b10) begin
         failures++;
         $display("FAIL reset_wait_pop: got lat=%0d err=%b expected 1/10", lat, err);
      end
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_push_basic();
      test_round_robin();
      test_full();
      test_pop();
      test_drop();
      test_timeout();
      test_reset_in_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pq_cmd_arbiter.md
Name: pq_cmd_arbiter

Overview:
- Round-robin arbiter and sequencer in front of the array priority queue (chain of cell FSMs).
- Accepts push/pop/drop commands from NR requesters and issues exactly one command at a time to the head cell.
- Waits for the head cell's valid strobe, then returns a one-cycle response to the granted requester.
- Tracks occupancy, rejects illegal operations without touching the queue, and times out hung operations.

Parameters:
NR, 4, number of requesters (2..8)
TW, 4, task ID width; ID 0 is reserved as "empty"
PW, 8, priority width
DEPTH, 8, queue capacity in entries (number of cells)
TO_CYC, 15, maximum WAIT cycles before timeout (1..255)

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
req_i  in  NR  per-requester request; held with operands until gnt_o
op_i  in  2*NR  per-requester op: 00 push, 01 pop, 10 drop, 11 reserved
id_i  in  TW*NR  per-requester task ID (push/drop)
prio_i  in  PW*NR  per-requester priority (push)
gnt_o  in/out: out  NR  one-hot, one-cycle grant
rsp_vld_o  out  1  one-cycle response strobe
rsp_idx_o  out  $clog2(NR)  requester index the response belongs to
rsp_err_o  out  2  00 ok, 01 full, 10 empty/miss, 11 timeout
rsp_id_o  out  TW  popped ID (pop), echoed ID (push/drop)
rsp_prio_o  out  PW  popped priority (pop), else echoed/0
pq_push_o  out  1  push command to head cell
pq_pop_o  out  1  pop command to head cell
pq_drop_o  out  1  drop command to head cell
pq_id_o  out  TW  push ID
pq_prio_o  out  PW  push priority
pq_drop_id_o  out  TW  drop target ID
pq_push_vld_i  in  1  head push complete
pq_pop_vld_i  in  1  head pop complete; pq_id_i/pq_prio_i valid
pq_drop_vld_i  in  1  head drop complete
pq_drop_hit_i  in  1  qualifies pq_drop_vld_i: ID was found
pq_id_i  in  TW  popped ID
pq_prio_i  in  PW  popped priority
count_o  out  $clog2(DEPTH+1)  occupancy
full_o  out  1  count_o == DEPTH
empty_o  out  1  count_o == 0
busy_o  out  1  state != IDLE

Behaviour:
- Reset, synchronous on rst_ni low at a clock edge (clears an in-flight op):
  - state = IDLE, count = 0, rr pointer = NR-1 (requester 0 wins first).
  - All outputs 0 except empty_o = 1.
  - The queue shares the same reset.
- States:
  - IDLE: if any req_i is set, pick the first requester at or after ptr+1 (modulo NR).
    - gnt_o is asserted combinationally in that same cycle.
    - Capture op, ID and priority; ptr <= winner.
    - Op legality:
      - reserved op -> RESP with err 10
      - push with count == DEPTH -> RESP with err 01
      - pop/drop with count == 0 -> RESP with err 10
      - otherwise -> ISSUE
  - ISSUE: pulse exactly one of pq_push_o/pq_pop_o/pq_drop_o for one cycle, with captured operands on pq_id_o/pq_prio_o/pq_drop_id_o. Clear timeout counter. -> WAIT.
  - WAIT: only the vld matching the captured op is honoured; the others are ignored.
    - On it: latch pq_id_i/pq_prio_i (pop), set err (drop without hit -> 10), -> RESP.
    - Timeout counter increments each WAIT cycle; when it reaches TO_CYC with no vld -> RESP with err 11.
  - RESP: rsp_vld_o = 1 for one cycle with rsp_idx_o and data.
    - Count update on err 00 only: push +1, pop -1, drop hit -1.
    - -> IDLE.
- Latency:
  - Legal op: grant at cycle t, command at t+1, response 1 cycle after vld (min t+3).
  - Rejected op: response at t+1.
- Operands on pq_* outputs hold the captured value from ISSUE through RESP; they are 0 in IDLE.
- At most one op in flight. Requests arriving in non-IDLE states wait; no grant outside IDLE.
- Back-to-back: the next grant is possible in the IDLE cycle immediately after RESP.
- A requester dropping req_i before grant is legal and is not granted.
- Timeout does not change count; software must reset the queue.

Test Plan:
- After reset, req_i=0001 push ID 3, prio 5 -> gnt_o=0001 at t; pq_push_o at t+1; drive pq_push_vld_i at t+2 -> rsp_vld_o at t+3 with err 00, idx 0; count_o 1.
- All 4 requesters push simultaneously and hold -> grants in order 0,1,2,3 on successive IDLE cycles; count_o=4.
- count=DEPTH=8, push -> no pq_push_o, rsp at t+1 with err 01; count stays 8, full_o=1.
- Pop on empty -> err 10 at t+1. Then push ID 7 prio 9 and pop, with pq_pop_vld_i returning ID 7 prio 9 -> rsp_id_o=7, rsp_prio_o=9, count_o back to 0.
- Drop ID 4 with pq_drop_vld_i=1 and pq_drop_hit_i=0 -> err 10, count unchanged. With hit=1 -> err 00, count decrements.
- Push with no vld returned -> after 15 WAIT cycles, rsp err 11. Separately, assert rst_ni=0 during WAIT -> next cycle is IDLE with all outputs zero and count_o=0.
